// File: rtl/jtframe_rom_nslots_rr.sv
// Round-robin SDRAM read arbiter: SLOTS clients, each with a one-entry cache,
// sharing one 16-bit SDRAM bank port.

module jtframe_rom_nslots_rr_cache #(
  parameter int          AW     = 17,
  parameter int          DW     = 32,
  parameter logic [21:0] OFFSET = 22'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          clr,
  input  logic          wr,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          ok,
  output logic [DW-1:0] dout,
  output logic [21:0]   word_addr
);
  logic [AW-1:0] caddr;
  logic          valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      caddr <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (wr) begin
        caddr <= wr_addr;
        dout  <= wr_data;
      end
      // a clear always beats a completing fetch for the same slot
      if (clr)     valid <= 1'b0;
      else if (wr) valid <= wr_valid;
    end
  end

  assign ok = cs & valid & (caddr == addr);

  generate
    if (DW == 8) begin : g_w8
      assign word_addr = 22'(addr >> 1) + OFFSET;
    end else if (DW == 16) begin : g_w16
      assign word_addr = 22'(addr) + OFFSET;
    end else begin : g_w32
      assign word_addr = 22'({addr, 1'b0}) + OFFSET;
    end
  endgenerate
endmodule

module jtframe_rom_nslots_rr #(
  parameter int                   SLOTS   = 4,
  parameter int                   SLOT_AW = 17,
  parameter int                   SLOT_DW = 32,
  parameter logic [22*SLOTS-1:0]  OFFSETS = {SLOTS{22'd0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SLOTS*SLOT_AW-1:0]   slot_addr,
  input  logic [SLOTS-1:0]           slot_cs,
  input  logic [SLOTS-1:0]           slot_clr,
  output logic [SLOTS-1:0]           slot_ok,
  output logic [SLOTS*SLOT_DW-1:0]   slot_dout,
  output logic [21:0]                sdram_addr,
  output logic                       sdram_req,
  input  logic                       sdram_ack,
  input  logic                       data_dst,
  input  logic                       data_rdy,
  input  logic [15:0]                data_read
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  state_t st, st_nx;

  logic [IW-1:0]             rr, sel, pick;
  logic                      any_miss, done, clr_pend, wr_valid;
  logic [SLOTS-1:0]          miss;
  logic [SLOTS-1:0][21:0]    waddr;
  logic [SLOT_AW-1:0]        sel_addr;
  logic [15:0]               lo_half;
  logic [SLOT_DW-1:0]        wr_data;

  assign miss     = slot_cs & ~slot_ok;
  assign done     = (st == WAIT_DATA) & data_rdy;
  assign wr_valid = ~(clr_pend | slot_clr[sel]);

  // Scan from rr upwards with wrap; the last hit in a descending scan is the
  // nearest one to rr.
  always_comb begin
    pick     = '0;
    any_miss = 1'b0;
    for (int k = SLOTS-1; k >= 0; k--) begin
      if (miss[(int'(rr) + k) % SLOTS]) begin
        pick     = IW'((int'(rr) + k) % SLOTS);
        any_miss = 1'b1;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    if (SLOT_DW == 32)
      wr_data = SLOT_DW'(data_dst ? {16'h0, data_read} : {data_read, lo_half});
    else if (SLOT_DW == 16)
      wr_data = SLOT_DW'(data_read);
    else
      wr_data = SLOT_DW'(sel_addr[0] ? data_read[15:8] : data_read[7:0]);
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:      if (any_miss)  st_nx = WAIT_ACK;
      WAIT_ACK:  if (sdram_ack) st_nx = WAIT_DATA;
      WAIT_DATA: if (data_rdy)  st_nx = IDLE;
      default:                  st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      rr         <= '0;
      sel        <= '0;
      sel_addr   <= '0;
      lo_half    <= '0;
      clr_pend   <= 1'b0;
    end else begin
      case (st)
        IDLE: if (any_miss) begin
          sel        <= pick;
          sel_addr   <= slot_addr[SLOT_AW*int'(pick) +: SLOT_AW];
          sdram_addr <= waddr[pick];
          sdram_req  <= 1'b1;
          clr_pend   <= 1'b0;
        end
        WAIT_ACK: begin
          if (sdram_ack)     sdram_req <= 1'b0;
          if (slot_clr[sel]) clr_pend  <= 1'b1;
        end
        WAIT_DATA: begin
          if (slot_clr[sel]) clr_pend <= 1'b1;
          if (data_dst)      lo_half  <= data_read;
          if (data_rdy)      rr       <= IW'((int'(sel) + 1) % SLOTS);
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      jtframe_rom_nslots_rr_cache #(
        .AW     (SLOT_AW),
        .DW     (SLOT_DW),
        .OFFSET (OFFSETS[22*i +: 22])
      ) u_cache (
        .clk       (clk),
        .rst       (rst),
        .addr      (slot_addr[SLOT_AW*i +: SLOT_AW]),
        .cs        (slot_cs[i]),
        .clr       (slot_clr[i]),
        .wr        (done && (sel == IW'(i))),
        .wr_valid  (wr_valid),
        .wr_addr   (sel_addr),
        .wr_data   (wr_data),
        .ok        (slot_ok[i]),
        .dout      (slot_dout[SLOT_DW*i +: SLOT_DW]),
        .word_addr (waddr[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_jtframe_rom_nslots_rr.sv
// Directed bench: DW=16 four-slot arbiter plus DW=32 and DW=8 two-slot
// instances sharing the SDRAM response signals.
module tb_jtframe_rom_nslots_rr;
  logic        clk = 0, rst = 1;
  logic        ack = 0, dst = 0, rdy = 0;
  logic [15:0] dread = '0;

  logic [67:0] a16 = '0;  logic [3:0] cs16 = '0, clr16 = '0, ok16;
  logic [63:0] dout16;    logic [21:0] sa16; logic req16;
  logic [33:0] a32 = '0;  logic [1:0] cs32 = '0, clr32 = '0, ok32;
  logic [63:0] dout32;    logic [21:0] sa32; logic req32;
  logic [33:0] a8 = '0;   logic [1:0] cs8 = '0, clr8 = '0, ok8;
  logic [15:0] dout8;     logic [21:0] sa8;  logic req8;

  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  jtframe_rom_nslots_rr #(.SLOTS(4), .SLOT_AW(17), .SLOT_DW(16),
    .OFFSETS({22'h400, 22'h300, 22'h200, 22'h100000})) u16 (
    .clk(clk), .rst(rst), .slot_addr(a16), .slot_cs(cs16), .slot_clr(clr16),
    .slot_ok(ok16), .slot_dout(dout16), .sdram_addr(sa16), .sdram_req(req16),
    .sdram_ack(ack), .data_dst(dst), .data_rdy(rdy), .data_read(dread));

  jtframe_rom_nslots_rr #(.SLOTS(2), .SLOT_AW(17), .SLOT_DW(32),
    .OFFSETS(44'd0)) u32 (
    .clk(clk), .rst(rst), .slot_addr(a32), .slot_cs(cs32), .slot_clr(clr32),
    .slot_ok(ok32), .slot_dout(dout32), .sdram_addr(sa32), .sdram_req(req32),
    .sdram_ack(ack), .data_dst(dst), .data_rdy(rdy), .data_read(dread));

  jtframe_rom_nslots_rr #(.SLOTS(2), .SLOT_AW(17), .SLOT_DW(8),
    .OFFSETS(44'd0)) u8 (
    .clk(clk), .rst(rst), .slot_addr(a8), .slot_cs(cs8), .slot_clr(clr8),
    .slot_ok(ok8), .slot_dout(dout8), .sdram_addr(sa8), .sdram_req(req8),
    .sdram_ack(ack), .data_dst(dst), .data_rdy(rdy), .data_read(dread));

  function automatic logic req_of(input int d);
    return d == 0 ? req16 : d == 1 ? req32 : req8;
  endfunction

  function automatic logic [21:0] addr_of(input int d);
    return d == 0 ? sa16 : d == 1 ? sa32 : sa8;
  endfunction

  // Waits (bounded) for a request, acks it and returns data.
  // mode 0: rdy only with hi; 1: dst(lo) then rdy(hi); 2: dst+rdy together with lo.
  task automatic bus(input int d, input int mode, input logic [15:0] lo, hi,
                     output logic [21:0] addr, output bit to);
    to = 1; addr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_of(d)) begin to = 0; break; end
    end
    if (!to) begin
      addr = addr_of(d);
      ack = 1; @(negedge clk); ack = 0;
      if (mode == 1) begin dst = 1; dread = lo; @(negedge clk); dst = 0; end
      rdy = 1; dst = (mode == 2); dread = (mode == 2) ? lo : hi;
      @(negedge clk); rdy = 0; dst = 0;
    end
  endtask

  task automatic wait_req(output bit to);
    to = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req16) begin to = 0; break; end
    end
  endtask

  task automatic pulse_rst;
    @(negedge clk); rst = 1; cs16 = '0; cs32 = '0; cs8 = '0;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tot++; if (req16 !== 1'b0 || req32 !== 1'b0) $display("FAIL reset_req: got %b%b want 00", req16, req32); else n_pass++;
    n_tot++; if (sa16 !== 22'h0) $display("FAIL reset_addr: got %h want 0", sa16); else n_pass++;
    n_tot++; if (ok16 !== 4'h0 || dout16 !== 64'h0) $display("FAIL reset_ok_dout: got %h/%h want 0/0", ok16, dout16); else n_pass++;
    rst = 0;
  endtask

  task automatic test_dw16;
    @(negedge clk); a16[16:0] = 17'h10; cs16 = 4'b0001; #1;
    n_tot++; if (ok16[0] !== 1'b0) $display("FAIL dw16_miss_ok: got %b want 0", ok16[0]); else n_pass++;
    @(negedge clk);
    n_tot++; if (req16 !== 1'b1 || sa16 !== 22'h100010) $display("FAIL dw16_req: got %b/%h want 1/100010", req16, sa16); else n_pass++;
    @(negedge clk);
    n_tot++; if (req16 !== 1'b1) $display("FAIL dw16_req_hold: got %b want 1", req16); else n_pass++;
    ack = 1; @(negedge clk); ack = 0;
    n_tot++; if (req16 !== 1'b0) $display("FAIL dw16_req_drop: got %b want 0", req16); else n_pass++;
    rdy = 1; dread = 16'hBEEF; @(negedge clk); rdy = 0;
    n_tot++; if (ok16[0] !== 1'b1 || dout16[15:0] !== 16'hBEEF) $display("FAIL dw16_data: got %b/%h want 1/beef", ok16[0], dout16[15:0]); else n_pass++;
    cs16 = 4'b0000; #1;
    n_tot++; if (ok16[0] !== 1'b0) $display("FAIL dw16_cs_low_ok: got %b want 0", ok16[0]); else n_pass++;
    @(negedge clk); cs16 = 4'b0001; #1;
    n_tot++; if (ok16[0] !== 1'b1) $display("FAIL dw16_hit_same_cycle: got %b want 1", ok16[0]); else n_pass++;
    @(negedge clk);
    n_tot++; if (req16 !== 1'b0) $display("FAIL dw16_hit_no_req: got %b want 0", req16); else n_pass++;
    cs16 = '0;
  endtask

  task automatic test_dw32;
    logic [21:0] ad; bit to;
    @(negedge clk); a32[16:0] = 17'h5; cs32 = 2'b01;
    bus(1, 1, 16'h1234, 16'hABCD, ad, to);
    n_tot++; if (to || ad !== 22'h00000A) $display("FAIL dw32_addr: got %h (timeout %0d) want 00000a", ad, to); else n_pass++;
    n_tot++; if (ok32[0] !== 1'b1 || dout32[31:0] !== 32'hABCD1234) $display("FAIL dw32_data: got %b/%h want 1/abcd1234", ok32[0], dout32[31:0]); else n_pass++;
    a32[16:0] = 17'h6; #1;
    n_tot++; if (ok32[0] !== 1'b0) $display("FAIL dw32_addr_change_ok: got %b want 0", ok32[0]); else n_pass++;
    bus(1, 2, 16'h5555, 16'hFFFF, ad, to);
    n_tot++; if (to || ad !== 22'h00000C) $display("FAIL dw32_addr2: got %h (timeout %0d) want 00000c", ad, to); else n_pass++;
    n_tot++; if (dout32[31:0] !== 32'h00005555) $display("FAIL dw32_coincident: got %h want 00005555", dout32[31:0]); else n_pass++;
    cs32 = '0;
  endtask

  task automatic test_dw8;
    logic [21:0] ad; bit to;
    @(negedge clk); a8[16:0] = 17'h7; cs8 = 2'b01;
    bus(2, 0, 16'h0, 16'h5AA5, ad, to);
    n_tot++; if (to || ad !== 22'h3) $display("FAIL dw8_addr: got %h (timeout %0d) want 000003", ad, to); else n_pass++;
    n_tot++; if (ok8[0] !== 1'b1 || dout8[7:0] !== 8'h5A) $display("FAIL dw8_high_byte: got %b/%h want 1/5a", ok8[0], dout8[7:0]); else n_pass++;
    a8[16:0] = 17'h6; #1;
    n_tot++; if (ok8[0] !== 1'b0) $display("FAIL dw8_new_addr_ok: got %b want 0", ok8[0]); else n_pass++;
    bus(2, 0, 16'h0, 16'h5AA5, ad, to);
    n_tot++; if (to || ad !== 22'h3 || dout8[7:0] !== 8'hA5) $display("FAIL dw8_low_byte: got %h/%h want 000003/a5", ad, dout8[7:0]); else n_pass++;
    cs8 = '0;
  endtask

  task automatic test_round_robin;
    logic [21:0] exp_a [5] = '{22'h100020, 22'h221, 22'h322, 22'h423, 22'h100030};
    logic [21:0] ad; bit to;
    pulse_rst;
    for (int i = 0; i < 4; i++) a16[17*i +: 17] = 17'(32'h20 + i);
    cs16 = 4'hF;
    for (int n = 0; n < 5; n++) begin
      bus(0, 0, 16'h0, 16'(16'hC000 + n), ad, to);
      n_tot++; if (to || ad !== exp_a[n]) $display("FAIL rr_grant%0d: got %h (timeout %0d) want %h", n, ad, to, exp_a[n]); else n_pass++;
      if (n == 0) a16[16:0] = 17'h30;
    end
    n_tot++; if (ok16 !== 4'hF || dout16[31:16] !== 16'hC001) $display("FAIL rr_all_ok: got %h/%h want f/c001", ok16, dout16[31:16]); else n_pass++;
    cs16 = '0;
  endtask

  task automatic test_clr;
    logic [21:0] ad; bit to;
    pulse_rst;
    a16[34 +: 17] = 17'h5; cs16 = 4'b0100;
    wait_req(to);
    n_tot++; if (to || sa16 !== 22'h305) $display("FAIL clr_req_addr: got %h (timeout %0d) want 000305", sa16, to); else n_pass++;
    ack = 1; @(negedge clk); ack = 0;
    clr16 = 4'b0100; @(negedge clk); clr16 = '0;
    rdy = 1; dread = 16'h1111; @(negedge clk); rdy = 0;
    n_tot++; if (ok16[2] !== 1'b0) $display("FAIL clr_inflight_ok: got %b want 0", ok16[2]); else n_pass++;
    @(negedge clk);
    n_tot++; if (req16 !== 1'b1 || sa16 !== 22'h305) $display("FAIL clr_rerequest: got %b/%h want 1/000305", req16, sa16); else n_pass++;
    bus(0, 0, 16'h0, 16'h2222, ad, to);
    n_tot++; if (to || ok16[2] !== 1'b1 || dout16[47:32] !== 16'h2222) $display("FAIL clr_refetch: got %b/%h want 1/2222", ok16[2], dout16[47:32]); else n_pass++;
    clr16 = 4'b0100; @(negedge clk); clr16 = '0;
    n_tot++; if (ok16[2] !== 1'b0) $display("FAIL clr_on_hit: got %b want 0", ok16[2]); else n_pass++;
    bus(0, 0, 16'h0, 16'h2222, ad, to);
  endtask

  task automatic test_rst_mid;
    logic [21:0] ad; bit to;
    @(negedge clk); a16[17 +: 17] = 17'h7; cs16 = 4'b0110;
    wait_req(to);
    n_tot++; if (to || sa16 !== 22'h207 || ok16 !== 4'b0100) $display("FAIL rstmid_req: got %h/%h want 000207/4", sa16, ok16); else n_pass++;
    rst = 1; #1;
    n_tot++; if (req16 !== 1'b0 || ok16 !== 4'h0) $display("FAIL rstmid_clear: got %b/%h want 0/0", req16, ok16); else n_pass++;
    @(negedge clk); rst = 0;
    bus(0, 0, 16'h0, 16'h7777, ad, to);
    n_tot++; if (to || ad !== 22'h207) $display("FAIL rstmid_reissue: got %h (timeout %0d) want 000207", ad, to); else n_pass++;
    bus(0, 0, 16'h0, 16'h8888, ad, to);
    n_tot++; if (to || ad !== 22'h305 || ok16 !== 4'b0110) $display("FAIL rstmid_next: got %h/%h want 000305/6", ad, ok16); else n_pass++;
    cs16 = '0;
  endtask

  initial begin
    test_reset;
    test_dw16;
    test_dw32;
    test_dw8;
    test_round_robin;
    test_clr;
    test_rst_mid;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
